uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 104, meaning clk cycles per serial bit (115200 baud at 12 MHz); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial data line, idle high.
REQ-005 SHALL have port data  output  8  last correctly framed character received.
REQ-006 SHALL have port rcv  output  1  one-cycle pulse: new character valid on data.
REQ-007 SHALL have port ferr  output  1  one-cycle pulse: framing error (stop bit sampled 0).
REQ-008 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, preset to 1; rxs below denotes the synchronizer output, lagging the rx pin by 2 cycles.
REQ-010 SHALL use a frame format of 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1, no parity.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: on the first cycle t0 with rxs==0, SHALL load the bit-timer and go to START.
REQ-013 START: at t0+floor(BAUDRATE/2), SHALL sample rxs; if 0, go to DATA, else go to IDLE (glitch rejected, no pulse).
REQ-014 DATA: SHALL sample bit i (i=0..7) at t0+floor(BAUDRATE/2)+(i+1)*BAUDRATE and shift it into an 8-bit register LSB first; after bit 7, go to STOP.
REQ-015 STOP: SHALL sample rxs at t0+floor(BAUDRATE/2)+9*BAUDRATE.
REQ-016 If the stop sample is 1, SHALL load data from the shift register and assert rcv in the next cycle only, then enter IDLE in that same cycle.
REQ-017 If the stop sample is 0, SHALL leave data unchanged, assert ferr for one cycle, and enter BREAK.
REQ-018 BREAK: SHALL remain until rxs==1, then go to IDLE; a line held low SHALL produce exactly one ferr.
REQ-019 The bit-timer SHALL be a down-counter of width ceil(log2(BAUDRATE)) bits, reloaded at every sample point; it SHALL not free-run in IDLE or BREAK.
REQ-020 rcv and ferr SHALL never be asserted in the same cycle, and neither SHALL be high for more than one consecutive cycle.
REQ-021 data SHALL change only in the cycle rcv rises and SHALL hold its value otherwise, including across ferr events.
REQ-022 Back-to-back frames SHALL be supported: a start edge on rxs in the first IDLE cycle after rcv SHALL be accepted with no lost character.
REQ-023 rx transitions between sample points SHALL be ignored; only the single mid-bit sample counts.
REQ-024 busy SHALL be 1 in START, DATA, STOP, and BREAK, and 0 in IDLE.

Reset
REQ-025 With rstn==0 at a clk edge, SHALL set state=IDLE, synchronizer flops=1, shift register=0, data=8'h00, rcv=0, ferr=0, busy=0, bit-timer=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rcv and no ferr; after release, SHALL require rxs==0 to be seen again in IDLE before accepting a new frame.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Verification (bench uses BAUDRATE=8 unless noted)
REQ-028 Send 0x48 ('H') at 8 cycles/bit -> exactly one rcv pulse, data==8'h48, ferr stays 0, busy returns to 0.
REQ-029 Send "Hola" back-to-back with no idle gap -> four rcv pulses with data 0x48, 0x6F, 0x6C, 0x61 in order.
REQ-030 Drive rx low for 2 cycles, then high -> no rcv, no ferr, busy high briefly then 0.
REQ-031 Send 0x55 with the stop bit forced 0, then hold rx low for 40 cycles -> exactly one ferr, data keeps its previous value (0x61), no rcv until rx returns high and a good frame follows.
REQ-032 Assert rstn low during data bit 4 of a frame, then release -> no rcv, no ferr, data==8'h00; the next full frame 0x21 is received correctly.
REQ-033 With BAUDRATE=104, send 0xA5 at a transmitter period of 102 and of 106 cycles/bit -> data==8'hA5 in both cases.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial receive channel: the line toward the receiver plus the received
// character and its status pulses.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       rcv;
   logic       ferr;
   logic       busy;

   modport master (output rx, input data, rcv, ferr, busy);
   modport slave  (input rx, output data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its midpoint with a
// reloadable down-counter, and reports good characters and framing errors.
module uart_rx #(
   parameter int BAUDRATE = 104
) (
   input logic     clk,
   input logic     rstn,
   uart_rx_if.slave bus
);

   localparam int TW = $clog2(BAUDRATE);
   localparam logic [TW-1:0] HALF_LOAD = TW'(BAUDRATE / 2 - 1);
   localparam logic [TW-1:0] FULL_LOAD = TW'(BAUDRATE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          rcv_q, rcv_d;
   logic          ferr_q, ferr_d;
   logic          busy;
   logic          rxs;
   logic          tick;

   assign rxs  = sync_q[1];
   assign tick = (timer_q == '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         sync_q   <= 2'b11;
         timer_q  <= '0;
         bitCnt_q <= 3'd0;
         shift_q  <= 8'h00;
         data_q   <= 8'h00;
         rcv_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[0], bus.rx};
         timer_q  <= timer_d;
         bitCnt_q <= bitCnt_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         rcv_q    <= rcv_d;
         ferr_q   <= ferr_d;
      end
   end

   // Transitions only happen on a sample tick, except leaving IDLE and BREAK,
   // which react to the synchronized line level directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rxs) state_d = START;
         START:   if (tick) state_d = rxs ? IDLE : DATA;
         DATA:    if (tick && bitCnt_q == 3'd7) state_d = STOP;
         STOP:    if (tick) state_d = rxs ? IDLE : BREAK;
         BREAK:   if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d  = timer_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      data_d   = data_q;
      rcv_d    = 1'b0;
      ferr_d   = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            bitCnt_d = 3'd0;
            timer_d  = rxs ? '0 : HALF_LOAD;
         end
         START: begin
            timer_d = tick ? FULL_LOAD : timer_q - TW'(1);
         end
         DATA: begin
            if (tick) begin
               timer_d  = FULL_LOAD;
               shift_d  = {rxs, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         STOP: begin
            if (tick) begin
               timer_d = '0;
               if (rxs) begin
                  data_d = shift_q;
                  rcv_d  = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         BREAK: begin
            timer_d = '0;
         end
         default: begin
            timer_d = '0;
         end
      endcase
   end

   assign bus.data = data_q;
   assign bus.rcv  = rcv_q;
   assign bus.ferr = ferr_q;
   assign bus.busy = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (8 cycles/bit) for the framing
// cases and a 104 cycles/bit instance for transmitter clock tolerance.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   uart_rx_if if8 ();
   uart_rx_if if104 ();

   uart_rx #(.BAUDRATE(8)) dut8 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if8.slave)
   );

   uart_rx #(.BAUDRATE(104)) dut104 (
      .clk  (clk),
      .rstn (rstn),
      .bus  (if104.slave)
   );

   typedef struct {
      logic [7:0] txByte;
      int         gap;
      int         expRcv;
      int         expFerr;
      logic [7:0] expData;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int rcv8 = 0;
   int ferr8 = 0;
   int rcv104 = 0;
   int ferr104 = 0;
   int protoViol = 0;
   logic prevRcv8 = 1'b0;
   logic prevFerr8 = 1'b0;
   logic [7:0] prevData8 = 8'h00;

   // Count pulses and watch for overlapping, stretched, or unannounced data changes.
   always @(negedge clk) begin
      if (if8.rcv === 1'b1) rcv8++;
      if (if8.ferr === 1'b1) ferr8++;
      if (if8.rcv === 1'b1 && if8.ferr === 1'b1) protoViol++;
      if ((if8.rcv === 1'b1 && prevRcv8) || (if8.ferr === 1'b1 && prevFerr8)) protoViol++;
      if (rstn === 1'b1 && if8.data !== prevData8 && if8.rcv !== 1'b1) protoViol++;
      prevRcv8  = (if8.rcv === 1'b1);
      prevFerr8 = (if8.ferr === 1'b1);
      prevData8 = if8.data;
      if (if104.rcv === 1'b1) rcv104++;
      if (if104.ferr === 1'b1) ferr104++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives start, 8 data bits LSB first and the stop bit; rx is left at the stop level.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                                input int period, input bit use104);
      logic [9:0] frame;
      frame = {stopBit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (use104) if104.rx = frame[i];
         else        if8.rx   = frame[i];
         repeat (period) @(negedge clk);
      end
   endtask

   vec_t vecs[9];

   initial begin
      int r0;
      int f0;
      logic [9:0] partial;

      vecs[0] = '{8'h00, 4, 1, 0, 8'h00};
      vecs[1] = '{8'hFF, 4, 1, 0, 8'hFF};
      vecs[2] = '{8'h80, 4, 1, 0, 8'h80};
      vecs[3] = '{8'h01, 4, 1, 0, 8'h01};
      vecs[4] = '{8'h48, 4, 1, 0, 8'h48};
      vecs[5] = '{8'h48, 0, 1, 0, 8'h48};
      vecs[6] = '{8'h6F, 0, 1, 0, 8'h6F};
      vecs[7] = '{8'h6C, 0, 1, 0, 8'h6C};
      vecs[8] = '{8'h61, 4, 1, 0, 8'h61};

      rstn = 1'b0;
      if8.rx = 1'b1;
      if104.rx = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset data", if8.data, 8'h00);
      checkOutput("reset rcv", if8.rcv, 1'b0);
      checkOutput("reset ferr", if8.ferr, 1'b0);
      checkOutput("reset busy", if8.busy, 1'b0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         r0 = rcv8;
         f0 = ferr8;
         applyStimulus(vecs[i].txByte, 1'b1, 8, 1'b0);
         repeat (vecs[i].gap) @(negedge clk);
         checkOutput($sformatf("vec%0d rcv", i), rcv8 - r0, vecs[i].expRcv);
         checkOutput($sformatf("vec%0d ferr", i), ferr8 - f0, vecs[i].expFerr);
         checkOutput($sformatf("vec%0d data", i), if8.data, vecs[i].expData);
         checkOutput($sformatf("vec%0d busy", i), if8.busy, 1'b0);
      end

      // Short low glitch: start detected, rejected at mid-bit.
      r0 = rcv8;
      f0 = ferr8;
      if8.rx = 1'b0;
      repeat (2) @(negedge clk);
      if8.rx = 1'b1;
      @(negedge clk);
      checkOutput("glitch busy high", if8.busy, 1'b1);
      repeat (12) @(negedge clk);
      checkOutput("glitch busy low", if8.busy, 1'b0);
      checkOutput("glitch rcv", rcv8 - r0, 0);
      checkOutput("glitch ferr", ferr8 - f0, 0);

      // Bad stop bit followed by a held-low line.
      r0 = rcv8;
      f0 = ferr8;
      applyStimulus(8'h55, 1'b0, 8, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("break ferr", ferr8 - f0, 1);
      checkOutput("break rcv", rcv8 - r0, 0);
      checkOutput("break data", if8.data, 8'h61);
      checkOutput("break busy", if8.busy, 1'b1);
      if8.rx = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("break exit busy", if8.busy, 1'b0);
      checkOutput("break single ferr", ferr8 - f0, 1);
      applyStimulus(8'h33, 1'b1, 8, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("after break rcv", rcv8 - r0, 1);
      checkOutput("after break data", if8.data, 8'h33);

      // Reset in the middle of data bit 4.
      r0 = rcv8;
      f0 = ferr8;
      partial = {1'b1, 8'h3C, 1'b0};
      for (int i = 0; i < 5; i++) begin
         if8.rx = partial[i];
         repeat (8) @(negedge clk);
      end
      if8.rx = partial[5];
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      if8.rx = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("midreset rcv", rcv8 - r0, 0);
      checkOutput("midreset ferr", ferr8 - f0, 0);
      checkOutput("midreset data", if8.data, 8'h00);
      checkOutput("midreset busy", if8.busy, 1'b0);
      applyStimulus(8'h21, 1'b1, 8, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("post reset rcv", rcv8 - r0, 1);
      checkOutput("post reset data", if8.data, 8'h21);

      // Transmitter running slow and fast against the 104-cycle receiver.
      r0 = rcv104;
      f0 = ferr104;
      applyStimulus(8'hA5, 1'b1, 102, 1'b1);
      repeat (200) @(negedge clk);
      checkOutput("tol102 rcv", rcv104 - r0, 1);
      checkOutput("tol102 data", if104.data, 8'hA5);
      applyStimulus(8'hA5, 1'b1, 106, 1'b1);
      repeat (200) @(negedge clk);
      checkOutput("tol106 rcv", rcv104 - r0, 2);
      checkOutput("tol106 data", if104.data, 8'hA5);
      checkOutput("tol ferr", ferr104 - f0, 0);
      checkOutput("tol busy", if104.busy, 1'b0);

      checkOutput("pulse protocol", protoViol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
